// File: rtl/weight_fetch_seq.sv
`timescale 1ns/1ps
// Weight fetch sequencer: streams `length` 128-bit vectors from four 32-bit BRAM banks
// into a first-word-fall-through buffer, issuing reads only when buffer space is guaranteed.
module weight_fetch_seq #(
   parameter int ADDR_W     = 18,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] length,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [31:0]       bram_dout0,
   input  logic [31:0]       bram_dout1,
   input  logic [31:0]       bram_dout2,
   input  logic [31:0]       bram_dout3,
   output logic [127:0]      weight_out,
   output logic              weight_valid,
   input  logic              weight_ready,
   output logic              busy,
   output logic              done
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t             state, state_nxt;
   logic [ADDR_W-1:0]  addr_q, next_addr, len_q, issue_cnt, acc_cnt;
   logic [RD_LAT-1:0]  rd_pipe;
   logic [CNT_W-1:0]   inflight, occ;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [127:0]       mem [FIFO_DEPTH];
   logic               issue, cap, pop, last_issue, last_accept;

   assign cap          = rd_pipe[RD_LAT-1];
   assign weight_valid = (occ != '0);
   assign pop          = weight_valid && weight_ready;
   assign weight_out   = mem[rd_ptr];
   assign busy         = (state != IDLE);
   assign done         = (state == DONE);

   // A slot freed by this cycle's pop counts as available, so ready-high bursts run one per cycle.
   assign issue       = (state == FETCH) &&
                        ((inflight + occ) < (CNT_W'(FIFO_DEPTH) + CNT_W'(pop)));
   assign last_issue  = issue && (issue_cnt == len_q - ADDR_W'(1));
   assign last_accept = pop && (acc_cnt == len_q - ADDR_W'(1));

   // The issued address reaches the banks in the issue cycle; addr_q holds it afterwards.
   assign bram_addr = issue ? next_addr : addr_q;

   // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (length == '0) ? DONE : FETCH;
         FETCH:   if (last_issue) state_nxt = DRAIN;
         DRAIN:   if (last_accept) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         addr_q    <= '0;
         next_addr <= '0;
         len_q     <= '0;
         issue_cnt <= '0;
         acc_cnt   <= '0;
         rd_pipe   <= '0;
         inflight  <= '0;
         occ       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            next_addr <= base_addr;
            len_q     <= length;
            issue_cnt <= '0;
            acc_cnt   <= '0;
         end
         if (issue) begin
            addr_q    <= next_addr;
            next_addr <= next_addr + ADDR_W'(1);
            issue_cnt <= issue_cnt + ADDR_W'(1);
         end
         if (pop) acc_cnt <= acc_cnt + ADDR_W'(1);
         rd_pipe  <= (rd_pipe << 1) | RD_LAT'(issue);
         inflight <= inflight + CNT_W'(issue) - CNT_W'(cap);
         occ      <= occ + CNT_W'(cap) - CNT_W'(pop);
         if (cap) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
   end

   // NOTE: buffer storage is not reset; occupancy and pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (cap) mem[wr_ptr] <= {bram_dout0, bram_dout1, bram_dout2, bram_dout3};
   end

endmodule

// File: tb/tb_weight_fetch_seq.sv
`timescale 1ns/1ps
// Directed bench for weight_fetch_seq: a latency-accurate BRAM model feeds the DUT and a
// scoreboard queue of expected vectors is filled at start and drained on each acceptance.
module tb_weight_fetch_seq;

   localparam int ADDR_W     = 18;
   localparam int RD_LAT     = 2;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] length;
   logic [ADDR_W-1:0] bram_addr;
   logic [31:0]       bram_dout0, bram_dout1, bram_dout2, bram_dout3;
   logic [127:0]      weight_out;
   logic              weight_valid;
   logic              weight_ready;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;

   logic [127:0]      exp_q [$];
   logic [127:0]      exp_v;
   logic              hold_prev = 1'b0;
   logic [127:0]      prev_out = '0;
   logic [ADDR_W-1:0] last_addr = '0;
   int                issues_seen = 0;
   int                accepted_seen = 0;
   int                done_seen = 0;

   logic [ADDR_W-1:0] addr_d [RD_LAT];

   weight_fetch_seq #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .base_addr    (base_addr),
      .length       (length),
      .bram_addr    (bram_addr),
      .bram_dout0   (bram_dout0),
      .bram_dout1   (bram_dout1),
      .bram_dout2   (bram_dout2),
      .bram_dout3   (bram_dout3),
      .weight_out   (weight_out),
      .weight_valid (weight_valid),
      .weight_ready (weight_ready),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Bank k holds addr*4+k; data appears RD_LAT cycles after the address.
   always @(posedge clk) begin
      addr_d[0] <= bram_addr;
      for (int i = 1; i < RD_LAT; i++) addr_d[i] <= addr_d[i-1];
   end
   assign bram_dout0 = {12'd0, addr_d[RD_LAT-1], 2'd0};
   assign bram_dout1 = {12'd0, addr_d[RD_LAT-1], 2'd1};
   assign bram_dout2 = {12'd0, addr_d[RD_LAT-1], 2'd2};
   assign bram_dout3 = {12'd0, addr_d[RD_LAT-1], 2'd3};

   function automatic logic [127:0] vec_of(input logic [ADDR_W-1:0] a);
      return {12'd0, a, 2'd0, 12'd0, a, 2'd1, 12'd0, a, 2'd2, 12'd0, a, 2'd3};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_burst(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
      start     = 1'b1;
      base_addr = b;
      length    = n;
      for (int i = 0; i < int'(n); i++) exp_q.push_back(vec_of(b + ADDR_W'(i)));
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int waited = 0;
      forever begin
         @(negedge clk);
         if (done || waited >= budget) break;
         waited++;
      end
      check("done_seen", done, 1'b1);
      step(1);
   endtask

   // Output monitor: scoreboard pop on acceptance, hold stability, issue and done counting.
   always @(negedge clk) begin
      if (weight_valid && weight_ready) begin
         if (exp_q.size() == 0) begin
            check("vec_extra", weight_valid, 1'b0);
         end else begin
            exp_v = exp_q.pop_front();
            check("vec_data", weight_out, exp_v);
         end
         accepted_seen <= accepted_seen + 1;
      end
      if (hold_prev) begin
         check("hold_valid", weight_valid, 1'b1);
         check("hold_data", weight_out, prev_out);
      end
      hold_prev <= weight_valid && !weight_ready;
      prev_out  <= weight_out;
      if (busy && bram_addr !== last_addr) issues_seen <= issues_seen + 1;
      last_addr <= bram_addr;
      if (done) done_seen <= done_seen + 1;
   end

   initial begin
      #200000;
      $fatal(1, "FAIL watchdog expired before the directed sequence completed");
   end

   initial begin
      int first_k, done_k, d0, i0, a0;
      logic [ADDR_W-1:0] wrap_exp [4];
      wrap_exp = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};

      rst = 1'b0; start = 1'b0; base_addr = '0; length = '0; weight_ready = 1'b1;
      step(2);
      @(negedge clk);
      check("rst_addr", bram_addr, '0);
      check("rst_valid", weight_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      step(1);
      rst = 1'b1;
      step(1);

      // Basic burst: address sequence, first-valid latency, done latency.
      start_burst(18'h00010, 18'd4);
      first_k = -1;
      done_k  = -1;
      for (int k = 0; k < 20 && done_k < 0; k++) begin
         @(negedge clk);
         if (k == 0) check("t1_busy", busy, 1'b1);
         if (k < 4) check("t1_addr", bram_addr, 18'h00010 + ADDR_W'(k));
         if (k == 5) check("t1_addr_hold", bram_addr, 18'h00013);
         if (weight_valid && first_k < 0) first_k = k;
         if (done) done_k = k;
         step(1);
      end
      check("t1_first_valid", first_k, RD_LAT + 1);
      check("t1_done_lat", done_k, RD_LAT + 1 + 4);
      check("t1_sb_empty", exp_q.size(), 0);
      @(negedge clk);
      check("t1_busy_low", busy, 1'b0);
      check("t1_done_low", done, 1'b0);
      step(1);

      // Zero-length burst.
      start_burst(18'h00050, 18'd0);
      @(negedge clk);
      check("t2_busy", busy, 1'b1);
      check("t2_done", done, 1'b1);
      check("t2_addr", bram_addr, 18'h00013);
      check("t2_valid", weight_valid, 1'b0);
      step(1);
      @(negedge clk);
      check("t2_busy_low", busy, 1'b0);
      check("t2_done_low", done, 1'b0);
      check("t2_addr_hold", bram_addr, 18'h00013);
      step(1);

      // Address wrap at the top of the space.
      start_burst(18'h3FFFE, 18'd4);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t3_addr_wrap", bram_addr, wrap_exp[k]);
         step(1);
      end
      wait_done(30);
      check("t3_sb_empty", exp_q.size(), 0);

      // Backpressure: ready low for ten cycles mid-burst.
      d0 = done_seen; i0 = issues_seen; a0 = accepted_seen;
      start_burst(18'h00100, 18'd16);
      step(2);
      weight_ready = 1'b0;
      step(10);
      check("t4_held", (issues_seen - i0) - (accepted_seen - a0), FIFO_DEPTH);
      check("t4_valid_stall", weight_valid, 1'b1);
      weight_ready = 1'b1;
      wait_done(60);
      check("t4_accepted", accepted_seen - a0, 16);
      check("t4_sb_empty", exp_q.size(), 0);
      step(3);
      check("t4_done_once", done_seen - d0, 1);

      // Reset two cycles into a burst, then reset coinciding with start.
      d0 = done_seen;
      start_burst(18'h00200, 18'd8);
      step(2);
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("t5_addr", bram_addr, '0);
      check("t5_valid", weight_valid, 1'b0);
      check("t5_busy", busy, 1'b0);
      check("t5_done", done, 1'b0);
      step(6);
      check("t5_no_late_valid", weight_valid, 1'b0);
      check("t5_no_done", done_seen - d0, 0);
      rst = 1'b0; start = 1'b1; base_addr = 18'h00007; length = 18'd3;
      step(1);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      check("t5_start_in_rst", busy, 1'b0);
      step(1);
      start_burst(18'h00300, 18'd3);
      wait_done(30);
      check("t5_restart_sb", exp_q.size(), 0);
      check("t5_restart_done", done_seen - d0, 1);

      // Re-pulsed start during FETCH is ignored.
      d0 = done_seen; a0 = accepted_seen;
      start_burst(18'h00400, 18'd6);
      step(2);
      start = 1'b1; base_addr = 18'h00500; length = 18'd2;
      step(1);
      start = 1'b0;
      wait_done(40);
      check("t6_sb_empty", exp_q.size(), 0);
      check("t6_accepted", accepted_seen - a0, 6);
      step(5);
      check("t6_busy_low", busy, 1'b0);
      check("t6_done_once", done_seen - d0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
